// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The fetch FSM state encoding, reset defaults and word-address helpers live here.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES   = 32'd4;
  localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  // Wraps modulo 2^32 with no carry out.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + WORD_BYTES;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Architectural PC plus redirect bookkeeping (pending redirect, kill of in-flight fetch).
// Selects the next PC from {pc+4, redirect_pc, pend_pc} based on the fetch FSM state.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  fetch_state_e i_state,
  input  logic         i_redirect_valid,
  input  logic [31:0]  i_redirect_pc,
  input  logic         i_req_fire,
  input  logic         i_rsp_valid,
  input  logic         i_handshake,
  output logic [31:0]  o_pc,
  output logic [31:0]  o_pc4,
  output logic         o_kill
);

  logic [31:0] r_pc;
  logic [31:0] r_pend_pc;
  logic        r_pend;
  logic        r_kill;

  logic [31:0] w_redir_pc;
  logic        w_kill_eff;
  logic [31:0] w_pc_next;

  assign w_redir_pc = i_redirect_pc & ALIGN_MASK;
  // A redirect in the same cycle as a WAIT response also kills that response.
  assign w_kill_eff = r_kill | i_redirect_valid;

  always_comb begin
    w_pc_next = r_pc;
    case (i_state)
      ST_WAIT: begin
        if (i_rsp_valid && w_kill_eff) begin
          w_pc_next = i_redirect_valid ? w_redir_pc : r_pend_pc;
        end
      end
      ST_HOLD: begin
        if (i_redirect_valid) begin
          w_pc_next = w_redir_pc;
        end else if (i_handshake) begin
          w_pc_next = pc_plus4(r_pc);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_pend_pc <= RESET_PC;
      r_pend    <= 1'b0;
      r_kill    <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      if (i_redirect_valid) begin
        r_pend_pc <= w_redir_pc;
      end
      case (i_state)
        ST_REQ: begin
          // The request address must not move, so a redirect here becomes a kill once accepted.
          if (i_req_fire) begin
            r_kill <= r_pend | i_redirect_valid;
            r_pend <= 1'b0;
          end else if (i_redirect_valid) begin
            r_pend <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (i_rsp_valid) begin
            r_kill <= 1'b0;
          end else if (i_redirect_valid) begin
            r_kill <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_pc   = r_pc;
  assign o_pc4  = pc_plus4(r_pc);
  assign o_kill = w_kill_eff;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request at a time, {instr, pc+4} to decode.
// valid/ready: a transfer happens on a rising edge where valid && ready; valid holds with stable payload until then.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instruction,
  output logic [ADDR_W-1:0] if_pc4,
  output fetch_state_e      dbg_state
);

  fetch_state_e r_state;
  logic         r_req_valid;
  logic         r_if_valid;
  logic [31:0]  r_instr;
  logic [31:0]  r_pc4;

  logic [31:0]  w_pc;
  logic [31:0]  w_pc4;
  logic         w_kill;
  logic         w_req_fire;
  logic         w_handshake;

  assign w_req_fire  = r_req_valid & imem_req_ready;
  // Squash toward decode in any redirect cycle so no stale handshake completes.
  assign if_valid    = r_if_valid & ~redirect_valid;
  assign w_handshake = if_valid & if_ready;

  fetch_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_state          (r_state),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .i_req_fire       (w_req_fire),
    .i_rsp_valid      (imem_rsp_valid),
    .i_handshake      (w_handshake),
    .o_pc             (w_pc),
    .o_pc4            (w_pc4),
    .o_kill           (w_kill)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_REQ;
      r_req_valid <= 1'b0;
      r_if_valid  <= 1'b0;
      r_instr     <= '0;
      r_pc4       <= '0;
    end else begin
      case (r_state)
        ST_REQ: begin
          if (w_req_fire) begin
            r_state     <= ST_WAIT;
            r_req_valid <= 1'b0;
          end else begin
            r_req_valid <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            if (w_kill) begin
              r_state     <= ST_REQ;
              r_req_valid <= 1'b1;
            end else begin
              r_state    <= ST_HOLD;
              r_if_valid <= 1'b1;
              r_instr    <= imem_rsp_data;
              r_pc4      <= w_pc4;
            end
          end
        end
        ST_HOLD: begin
          if (redirect_valid || w_handshake) begin
            r_state     <= ST_REQ;
            r_if_valid  <= 1'b0;
            r_req_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_REQ;
          r_req_valid <= 1'b0;
          r_if_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = r_req_valid ? w_pc : '0;
  assign if_instruction = r_instr;
  assign if_pc4         = r_pc4;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cycle table, hand-written corner sequences,
// then randomized imem/decode/redirect traffic checked against a next-PC stream model.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [31:0]  imem_req_addr;
  logic         imem_rsp_valid;
  logic [31:0]  imem_rsp_data;
  logic         if_valid;
  logic         if_ready;
  logic [31:0]  if_instruction;
  logic [31:0]  if_pc4;
  fetch_state_e dbg_state;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instruction (if_instruction),
    .if_pc4         (if_pc4),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // ---------------- driver ----------------
  task automatic cyc(input logic rv, input logic [31:0] rpc, input logic rdy,
                     input logic rspv, input logic [31:0] rspd, input logic ifr);
    @(negedge clk);
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    imem_rsp_valid = rspv;
    imem_rsp_data  = rspd;
    if_ready       = ifr;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic erv, input logic [31:0] eaddr,
                         input logic eifv, input logic [31:0] einstr, input logic [31:0] epc4);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'(erv));
    chk({tag, "_req_addr"}, imem_req_addr, eaddr);
    chk({tag, "_if_valid"}, 32'(if_valid), 32'(eifv));
    chk({tag, "_instr"}, if_instruction, einstr);
    chk({tag, "_pc4"}, if_pc4, epc4);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if_ready       = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        rspv;
    logic [31:0] rspd;
    logic        ifr;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_ifv;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic rv, input logic [31:0] rpc, input logic rspv,
                         input logic [31:0] rspd, input logic e_rv, input logic [31:0] e_addr,
                         input logic e_ifv, input logic [31:0] e_instr, input logic [31:0] e_pc4);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.rdy = 1'b1; v.rspv = rspv; v.rspd = rspd; v.ifr = 1'b1;
    v.e_rv = e_rv; v.e_addr = e_addr; v.e_ifv = e_ifv; v.e_instr = e_instr; v.e_pc4 = e_pc4;
    vecs.push_back(v);
  endtask

  // ---------------- random-phase model state ----------------
  logic [31:0] exp_q[$];
  logic        mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          delivered;

  initial begin
    logic [31:0] d [0:8];
    logic [31:0] e_pc;
    logic        p_if_stall;
    logic        p_req_stall;
    logic [31:0] p_instr;
    logic [31:0] p_pc4;
    logic [31:0] p_addr;
    logic        rv;
    logic [31:0] rpc;
    logic        rspv;
    logic [31:0] rspd;

    for (int k = 0; k < 9; k++) d[k] = 32'hC0DE_0000 | 32'(k);

    // Reset state: outputs forced low regardless of inputs.
    rst_n          = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hFFFF_FFFF;
    if_ready       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("reset_state", 32'(dbg_state), 32'(ST_REQ));

    do_reset();

    // Fetch 0/4/8 back to back, redirect in WAIT, redirect in HOLD with if_ready,
    // redirect coinciding with a WAIT response.
    add_vec(0, 0,        0, 0,    1, 32'h0,    0, 0,    32'h0);
    add_vec(0, 0,        1, d[0], 0, 32'h0,    0, 0,    32'h0);
    add_vec(0, 0,        0, 0,    0, 32'h0,    1, d[0], 32'h4);
    add_vec(0, 0,        0, 0,    1, 32'h4,    0, d[0], 32'h4);
    add_vec(0, 0,        1, d[1], 0, 32'h0,    0, d[0], 32'h4);
    add_vec(0, 0,        0, 0,    0, 32'h0,    1, d[1], 32'h8);
    add_vec(0, 0,        0, 0,    1, 32'h8,    0, d[1], 32'h8);
    add_vec(0, 0,        1, d[2], 0, 32'h0,    0, d[1], 32'h8);
    add_vec(0, 0,        0, 0,    0, 32'h0,    1, d[2], 32'hC);
    add_vec(0, 0,        0, 0,    1, 32'hC,    0, d[2], 32'hC);
    add_vec(1, 32'h400,  0, 0,    0, 32'h0,    0, d[2], 32'hC);
    add_vec(0, 0,        1, d[3], 0, 32'h0,    0, d[2], 32'hC);
    add_vec(0, 0,        0, 0,    1, 32'h400,  0, d[2], 32'hC);
    add_vec(0, 0,        1, d[4], 0, 32'h0,    0, d[2], 32'hC);
    add_vec(0, 0,        0, 0,    0, 32'h0,    1, d[4], 32'h404);
    add_vec(0, 0,        0, 0,    1, 32'h404,  0, d[4], 32'h404);
    add_vec(0, 0,        1, d[5], 0, 32'h0,    0, d[4], 32'h404);
    add_vec(1, 32'h800,  0, 0,    0, 32'h0,    0, d[5], 32'h408);
    add_vec(0, 0,        0, 0,    1, 32'h800,  0, d[5], 32'h408);
    add_vec(0, 0,        1, d[6], 0, 32'h0,    0, d[5], 32'h408);
    add_vec(0, 0,        0, 0,    0, 32'h0,    1, d[6], 32'h804);
    add_vec(0, 0,        0, 0,    1, 32'h804,  0, d[6], 32'h804);
    add_vec(1, 32'h1003, 1, d[7], 0, 32'h0,    0, d[6], 32'h804);
    add_vec(0, 0,        0, 0,    1, 32'h1000, 0, d[6], 32'h804);
    add_vec(0, 0,        1, d[8], 0, 32'h0,    0, d[6], 32'h804);
    add_vec(0, 0,        0, 0,    0, 32'h0,    1, d[8], 32'h1004);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rv, vecs[i].rpc, vecs[i].rdy, vecs[i].rspv, vecs[i].rspd, vecs[i].ifr);
      chk_out($sformatf("vec%0d", i), vecs[i].e_rv, vecs[i].e_addr, vecs[i].e_ifv,
              vecs[i].e_instr, vecs[i].e_pc4);
    end

    // Backpressure in HOLD: payload stable, no new request until the handshake.
    cyc(0, 0, 1, 0, 0, 0);
    chk_out("bp_req", 1'b1, 32'h1004, 1'b0, d[8], 32'h1004);
    cyc(0, 0, 1, 1, 32'h2000_0005, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 0, 0, 0);
      chk_out($sformatf("bp_hold%0d", i), 1'b0, 32'h0, 1'b1, 32'h2000_0005, 32'h1008);
    end
    cyc(0, 0, 1, 0, 0, 1);
    chk("bp_release_if_valid", 32'(if_valid), 32'h1);

    // Redirect while the request is stalled: address held, old response killed.
    cyc(1, 32'h123, 0, 0, 0, 0);
    chk_out("stall_redir", 1'b1, 32'h1008, 1'b0, 32'h2000_0005, 32'h1008);
    cyc(0, 0, 0, 0, 0, 0);
    chk("stall_hold_addr", imem_req_addr, 32'h1008);
    cyc(0, 0, 1, 0, 0, 0);
    chk("stall_accept_addr", imem_req_addr, 32'h1008);
    cyc(0, 0, 1, 1, 32'hDEAD_BEEF, 1);
    chk("stall_killed_if_valid", 32'(if_valid), 32'h0);
    cyc(0, 0, 1, 0, 0, 1);
    chk_out("stall_newreq", 1'b1, 32'h120, 1'b0, 32'h2000_0005, 32'h1008);
    cyc(0, 0, 1, 1, 32'h1234_5678, 1);
    cyc(0, 0, 1, 0, 0, 1);
    chk_out("stall_deliver", 1'b0, 32'h0, 1'b1, 32'h1234_5678, 32'h124);

    // Redirect to the top word: pc+4 wraps to zero.
    cyc(0, 0, 1, 0, 0, 1);
    chk("wrap_req_addr", imem_req_addr, 32'h124);
    cyc(1, 32'hFFFF_FFFF, 1, 0, 0, 1);
    cyc(0, 0, 1, 1, 32'hDEAD_BEEF, 1);
    cyc(0, 0, 1, 0, 0, 1);
    chk("wrap_top_addr", imem_req_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 1, 1, 32'hABCD_0001, 1);
    cyc(0, 0, 1, 0, 0, 1);
    chk_out("wrap_deliver", 1'b0, 32'h0, 1'b1, 32'hABCD_0001, 32'h0);
    cyc(0, 0, 1, 0, 0, 1);
    chk_out("wrap_next_req", 1'b1, 32'h0, 1'b0, 32'hABCD_0001, 32'h0);

    // Asynchronous reset pulse while waiting for a response.
    cyc(0, 0, 1, 0, 0, 1);
    chk("mid_wait_state", 32'(dbg_state), 32'(ST_WAIT));
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n          = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_BAD0;
    cyc(0, 0, 1, 0, 0, 1);
    chk_out("post_reset_req", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    cyc(0, 0, 1, 1, 32'h0F0F_0F0F, 1);
    cyc(0, 0, 1, 0, 0, 1);
    chk_out("post_reset_deliver", 1'b0, 32'h0, 1'b1, 32'h0F0F_0F0F, 32'h4);

    // ---------------- randomized traffic vs next-PC stream model ----------------
    do_reset();
    exp_q.delete();
    exp_q.push_back(RESET_PC_DEF);
    mem_pend    = 1'b0;
    mem_cnt     = 0;
    mem_addr    = '0;
    delivered   = 0;
    p_if_stall  = 1'b0;
    p_req_stall = 1'b0;
    p_instr     = '0;
    p_pc4       = '0;
    p_addr      = '0;

    for (int c = 0; c < 3000; c++) begin
      rv  = ($urandom_range(0, 9) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      if (mem_pend && mem_cnt == 1) begin
        rspv     = 1'b1;
        rspd     = mem_f(mem_addr);
        mem_pend = 1'b0;
      end else begin
        rspv = 1'b0;
        rspd = $urandom;
        if (mem_pend) mem_cnt--;
      end
      cyc(rv, rpc, ($urandom_range(0, 3) != 0), rspv, rspd, ($urandom_range(0, 9) < 7));

      if (p_req_stall) begin
        chk("rnd_req_valid_held", 32'(imem_req_valid), 32'h1);
        chk("rnd_req_addr_held", imem_req_addr, p_addr);
      end
      if (p_if_stall && !rv) begin
        chk("rnd_if_valid_held", 32'(if_valid), 32'h1);
        chk("rnd_instr_held", if_instruction, p_instr);
        chk("rnd_pc4_held", if_pc4, p_pc4);
      end
      if (rv) chk("rnd_redirect_squash", 32'(if_valid), 32'h0);
      if (imem_req_valid) chk("rnd_addr_aligned", 32'(imem_req_addr[1:0]), 32'h0);

      if (if_valid && if_ready) begin
        delivered++;
        if (exp_q.size() == 0) begin
          chk("rnd_unexpected_delivery", 32'h1, 32'h0);
        end else begin
          e_pc = exp_q.pop_front();
          chk("rnd_pc4", if_pc4, e_pc + 32'd4);
          chk("rnd_instr", if_instruction, mem_f(e_pc));
          exp_q.push_back(e_pc + 32'd4);
        end
      end
      if (rv) begin
        exp_q.delete();
        exp_q.push_back(rpc & 32'hFFFF_FFFC);
      end

      if (imem_req_valid && imem_req_ready) begin
        chk("rnd_single_outstanding", 32'(mem_pend), 32'h0);
        mem_pend = 1'b1;
        mem_addr = imem_req_addr;
        mem_cnt  = $urandom_range(1, 3);
      end

      p_req_stall = imem_req_valid && !imem_req_ready;
      p_addr      = imem_req_addr;
      p_if_stall  = if_valid && !if_ready;
      p_instr     = if_instruction;
      p_pc4       = if_pc4;
    end
    chk("rnd_progress", 32'(delivered >= 100), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that owns the architectural PC register and consumes the next-PC value produced by the jump/branch next-PC mux. It issues one word-aligned fetch at a time to instruction memory over a valid/ready request channel and captures the response. It presents {instruction, PC+4} to decode over a valid/ready handshake. A redirect from the next-PC mux squashes any in-flight or held fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
ADDR_W, 32, PC/address width; fixed at 32 for this core

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset; active-low, asynchronous assert, synchronous deassert at the block boundary
redirect_valid  in  1  next-PC mux requests a PC change this cycle
redirect_pc  in  32  new PC; bits [1:0] ignored and forced to 00
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  imem accepts the request
imem_req_addr  out  32  word-aligned fetch address (= PC)
imem_rsp_valid  in  1  one-cycle pulse carrying read data; at most one per accepted request
imem_rsp_data  in  32  fetched instruction word
if_valid  out  1  instruction available to decode
if_ready  in  1  decode accepts
if_instruction  out  32  fetched instruction
if_pc4  out  32  address of if_instruction + 4

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=REQ, kill=0, pend=0. All outputs low or zero during reset. imem_req_valid first goes high in the first cycle after deassertion.
- FSM states:
  - REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready go to WAIT.
  - WAIT: wait for imem_rsp_valid. On response with kill=0: register data into if_instruction, if_pc4=pc+4, go to HOLD. On response with kill=1: discard it, pc=pend_pc, kill=0, go to REQ.
  - HOLD: if_valid=1 (registered). On if_valid&&if_ready: pc=pc+4, go to REQ.
- Address stability: imem_req_addr and imem_req_valid stay constant while in REQ until accepted. A redirect in REQ is therefore latched into pend_pc, and the kill flag is set on acceptance.
- Redirect handling, by state:
  - REQ, not accepted this cycle: pend=1, pend_pc=redirect_pc.
  - REQ, accepted this cycle: kill=1, pend_pc=redirect_pc.
  - WAIT: kill=1, pend_pc=redirect_pc. A response arriving in the same cycle is also discarded.
  - HOLD: drop the held instruction, pc=redirect_pc, go to REQ next cycle.
  - On WAIT-with-kill completion, a pending pend is consumed the same way.
- Redirect squash on output: if_valid is combinationally gated low while redirect_valid=1, so no handshake completes in a redirect cycle.
- Back-to-back redirects: the last one wins; pend_pc is overwritten.
- Arithmetic: pc+4 is modulo 2^32. 32'hFFFF_FFFC+4 = 32'h0000_0000, with no flag.
- Latency: with imem ready immediately and the response one cycle later, the request is at cycle N, the response at N+1, and if_valid at N+2.
- Throughput: at most one instruction per 3 cycles.
- if_valid backpressure: if_instruction and if_pc4 are held stable while if_valid=1 and if_ready=0.
- Reset mid-operation: an outstanding imem response after reset is ignored, because state=REQ is not WAIT.

Decomposition:
- Shared package fetch_pkg:
  - state enum (REQ, WAIT, HOLD)
  - RESET_PC default
  - WORD_BYTES=4
  - ALIGN_MASK=32'hFFFF_FFFC
- One sub-module, fetch_pc_reg:
  - holds pc, pend, pend_pc and kill
  - computes the next pc from {pc+4, redirect_pc, pend_pc}
- The FSM and output registers stay in fetch_unit.

Test Plan:
1. Reset release, imem always ready, response at +1, if_ready=1 -> requests 0x0, 0x4, 0x8 each 3 cycles apart; if_pc4 = 0x4, 0x8, 0xC; first if_valid 2 cycles after the first request.
2. Backpressure: if_ready=0 for 5 cycles in HOLD with instruction 0x2000_0005 -> if_valid stays 1 and data stays stable; no new imem request until the handshake.
3. Redirect in WAIT to 0x0000_0400 -> that response is discarded (if_valid stays 0); next imem_req_addr=0x400; delivered if_pc4=0x404.
4. Redirect while REQ stalled (imem_req_ready=0) to 0x0000_0123 -> addr held at the old pc until accepted; old response killed; next request addr=0x120.
5. Redirect in HOLD coinciding with if_ready=1 -> no handshake; next request at redirect_pc.
6. Redirect to 0xFFFF_FFFC -> if_pc4=0x0000_0000, next request addr 0x0; async rst_n pulse mid-WAIT -> outputs zero immediately, restart at RESET_PC.
